// File: rtl/uart_prog_loader.sv
// UART programming loader: receives 8N1 bytes, packs them little-endian into
// 32-bit words and drives the instruction ROM / data memory programming port.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 100,
  parameter int TIMEOUT_BITS = 40,
  parameter int MAX_WORDS    = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy_o,
  output logic        frame_err_o
);

  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_LIMIT - 1);
  localparam logic [14:0]      LAST_ADR  = 15'(MAX_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_RECV, L_DONE} ld_state_t;

  rx_state_t        rx_state;
  ld_state_t        ld_state;
  logic             rx_meta;
  logic             rxs;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             byte_valid;
  logic             stop_err;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_word;
  logic             seen_byte;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  // Receiver: start bit is re-checked at mid-bit so short glitches are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= R_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rxs) rx_state <= R_START;
        end
        R_START: begin
          if (clk_cnt == HALF_TICK) begin
            clk_cnt  <= '0;
            rx_state <= rxs ? R_IDLE : R_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (clk_cnt == LAST_TICK) begin
            clk_cnt   <= '0;
            shift_reg <= {rxs, shift_reg[7:1]};
            if (bit_cnt == 3'd7) rx_state <= R_STOP;
            else                 bit_cnt  <= bit_cnt + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (clk_cnt == LAST_TICK) begin
            clk_cnt    <= '0;
            byte_valid <= rxs;
            stop_err   <= ~rxs;
            rx_state   <= R_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Loader: the strobe cycle also decides between advancing the address and
  // finishing at capacity, so the address never wraps past the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state    <= L_IDLE;
      upg_wen_o   <= 1'b0;
      upg_adr_o   <= '0;
      upg_dat_o   <= '0;
      upg_done_o  <= 1'b1;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
      byte_idx    <= '0;
      asm_word    <= '0;
      seen_byte   <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      upg_wen_o <= 1'b0;
      case (ld_state)
        L_IDLE: begin
          if (start_i) begin
            ld_state    <= L_RECV;
            upg_done_o  <= 1'b0;
            busy_o      <= 1'b1;
            upg_adr_o   <= '0;
            byte_idx    <= '0;
            frame_err_o <= 1'b0;
            tmo_cnt     <= '0;
            seen_byte   <= 1'b0;
          end
        end
        L_RECV: begin
          if (stop_err) frame_err_o <= 1'b1;
          if (upg_wen_o && upg_adr_o == LAST_ADR) begin
            ld_state   <= L_DONE;
            upg_done_o <= 1'b1;
            busy_o     <= 1'b0;
          end else begin
            if (upg_wen_o) upg_adr_o <= upg_adr_o + 15'd1;
            if (byte_valid) begin
              seen_byte <= 1'b1;
              tmo_cnt   <= '0;
              case (byte_idx)
                2'd0: asm_word[7:0]   <= shift_reg;
                2'd1: asm_word[15:8]  <= shift_reg;
                2'd2: asm_word[23:16] <= shift_reg;
                default: begin
                  upg_dat_o <= {shift_reg, asm_word};
                  upg_wen_o <= 1'b1;
                end
              endcase
              byte_idx <= byte_idx + 2'd1;
            end else if (seen_byte) begin
              if (tmo_cnt == TMO_LAST) begin
                ld_state   <= L_DONE;
                upg_done_o <= 1'b1;
                busy_o     <= 1'b0;
                if (byte_idx != 2'd0) frame_err_o <= 1'b1;
              end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
              end
            end
          end
        end
        L_DONE: ld_state <= L_IDLE;
        default: ld_state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader: a default-capacity
// instance and a two-word instance share clock, reset, start and rx.
module tb_uart_prog_loader;

  localparam int CPB   = 16;
  localparam int TBITS = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        rx_i = 1'b1;

  logic        upg_wen_o, upg_done_o, busy_o, frame_err_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        cap_wen, cap_done, cap_busy, cap_ferr;
  logic [14:0] cap_adr_o;
  logic [31:0] cap_dat_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cap_done_cyc = -1;
  logic cap_done_q = 1'b1;

  logic [14:0] wr_adr[$];
  logic [31:0] wr_dat[$];
  logic [14:0] cap_adr[$];
  logic [31:0] cap_dat[$];
  int          cap_wr_cyc[$];

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TBITS), .MAX_WORDS(32768)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rx_i(rx_i),
    .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o), .busy_o(busy_o), .frame_err_o(frame_err_o)
  );

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TBITS), .MAX_WORDS(2)) dut_cap (
    .clk(clk), .rst(rst), .start_i(start_i), .rx_i(rx_i),
    .upg_wen_o(cap_wen), .upg_adr_o(cap_adr_o), .upg_dat_o(cap_dat_o),
    .upg_done_o(cap_done), .busy_o(cap_busy), .frame_err_o(cap_ferr)
  );

  // Write-port monitor: logs every strobe and the cycle the small instance finishes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (upg_wen_o) begin
      wr_adr.push_back(upg_adr_o);
      wr_dat.push_back(upg_dat_o);
    end
    if (cap_wen) begin
      cap_adr.push_back(cap_adr_o);
      cap_dat.push_back(cap_dat_o);
      cap_wr_cyc.push_back(cyc);
    end
    if (cap_done && !cap_done_q) cap_done_cyc <= cyc;
    cap_done_q <= cap_done;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic pulse_start();
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (upg_done_o !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, {31'd0, upg_done_o}, 32'd1);
  endtask

  initial begin : apply_stimulus
    int base;
    int cbase;

    // Reset state
    @(negedge clk);
    check_output("rst_done", {31'd0, upg_done_o}, 32'd1);
    check_output("rst_wen", {31'd0, upg_wen_o}, 32'd0);
    check_output("rst_adr", {17'd0, upg_adr_o}, 32'd0);
    check_output("rst_dat", upg_dat_o, 32'd0);
    check_output("rst_busy", {31'd0, busy_o}, 32'd0);
    check_output("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single word download");
    pulse_start();
    check_output("t1_done_low", {31'd0, upg_done_o}, 32'd0);
    check_output("t1_busy", {31'd0, busy_o}, 32'd1);
    base = wr_adr.size();
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check_output("t1_nwr", wr_adr.size() - base, 32'd1);
    if (wr_adr.size() > base) begin
      check_output("t1_wr_adr", {17'd0, wr_adr[base]}, 32'd0);
      check_output("t1_wr_dat", wr_dat[base], 32'h12345678);
    end
    check_output("t1_adr_next", {17'd0, upg_adr_o}, 32'd1);
    check_output("t1_dat_hold", upg_dat_o, 32'h12345678);
    wait_done(1000, "t1_done");
    check_output("t1_ferr", {31'd0, frame_err_o}, 32'd0);
    check_output("t1_busy_end", {31'd0, busy_o}, 32'd0);

    $display("[TB] two word download and timeout window");
    pulse_start();
    base = wr_adr.size();
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    repeat (600) @(negedge clk);
    check_output("t2_done_early", {31'd0, upg_done_o}, 32'd0);
    wait_done(100, "t2_done");
    check_output("t2_nwr", wr_adr.size() - base, 32'd2);
    if (wr_adr.size() >= base + 2) begin
      check_output("t2_adr0", {17'd0, wr_adr[base]}, 32'd0);
      check_output("t2_dat0", wr_dat[base], 32'h03020100);
      check_output("t2_adr1", {17'd0, wr_adr[base+1]}, 32'd1);
      check_output("t2_dat1", wr_dat[base+1], 32'h07060504);
    end
    check_output("t2_ferr", {31'd0, frame_err_o}, 32'd0);

    $display("[TB] partial trailing word");
    pulse_start();
    base = wr_adr.size();
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    wait_done(1000, "t3_done");
    check_output("t3_nwr", wr_adr.size() - base, 32'd1);
    if (wr_adr.size() > base) begin
      check_output("t3_adr", {17'd0, wr_adr[base]}, 32'd0);
      check_output("t3_dat", wr_dat[base], 32'hA3A2A1A0);
    end
    check_output("t3_ferr", {31'd0, frame_err_o}, 32'd1);
    pulse_start();
    check_output("t3_ferr_clr", {31'd0, frame_err_o}, 32'd0);
    check_output("t3_busy_again", {31'd0, busy_o}, 32'd1);

    $display("[TB] glitch and bad stop bit");
    base = wr_adr.size();
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    check_output("t4_glitch_ferr", {31'd0, frame_err_o}, 32'd0);
    check_output("t4_glitch_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check_output("t4_ferr_set", {31'd0, frame_err_o}, 32'd1);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    wait_done(1000, "t4_done");
    check_output("t4_nwr", wr_adr.size() - base, 32'd1);
    if (wr_adr.size() > base) begin
      check_output("t4_adr", {17'd0, wr_adr[base]}, 32'd0);
      check_output("t4_dat", wr_dat[base], 32'h55443311);
    end
    check_output("t4_ferr_sticky", {31'd0, frame_err_o}, 32'd1);

    $display("[TB] capacity limit with two words");
    do_reset();
    pulse_start();
    cbase = cap_adr.size();
    for (int i = 0; i < 12; i++) send_byte(8'h10 + 8'(i));
    check_output("t5_nwr", cap_adr.size() - cbase, 32'd2);
    if (cap_adr.size() >= cbase + 2) begin
      check_output("t5_adr0", {17'd0, cap_adr[cbase]}, 32'd0);
      check_output("t5_dat0", cap_dat[cbase], 32'h13121110);
      check_output("t5_adr1", {17'd0, cap_adr[cbase+1]}, 32'd1);
      check_output("t5_dat1", cap_dat[cbase+1], 32'h17161514);
      check_output("t5_done_lat", cap_done_cyc, cap_wr_cyc[cbase+1] + 1);
    end
    check_output("t5_done", {31'd0, cap_done}, 32'd1);
    check_output("t5_busy", {31'd0, cap_busy}, 32'd0);
    check_output("t5_ferr", {31'd0, cap_ferr}, 32'd0);

    $display("[TB] reset mid-byte");
    wait_done(1000, "t6_prev_done");
    pulse_start();
    base = wr_adr.size();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rx_i = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("t6_done", {31'd0, upg_done_o}, 32'd1);
    check_output("t6_wen", {31'd0, upg_wen_o}, 32'd0);
    check_output("t6_busy", {31'd0, busy_o}, 32'd0);
    check_output("t6_adr", {17'd0, upg_adr_o}, 32'd0);
    check_output("t6_dat", upg_dat_o, 32'd0);
    check_output("t6_ferr", {31'd0, frame_err_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (CPB * 6) @(negedge clk);
    rx_i = 1'b1;
    repeat (800) @(negedge clk);
    check_output("t6_no_strobe", wr_adr.size() - base, 32'd0);
    check_output("t6_done_after", {31'd0, upg_done_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART programmer stage that sits directly upstream of the instruction ROM and the data memory.
- Receives a raw 8N1 byte stream and packs bytes little-endian into 32-bit words.
- Drives the programming write port: upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o.
- upg_done_o=1 means the CPU runs normally; upg_done_o=0 means a download is in progress.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per UART bit; must be >= 4.
- TIMEOUT_BITS, 40, idle bit-times after the last byte that end a download.
- MAX_WORDS, 32768, word capacity; download ends after the write to address MAX_WORDS-1.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  arms a download when sampled high in L_IDLE.
- rx_i  in  1  UART serial input; asynchronous; idle level high.
- upg_wen_o  out  1  one-cycle write strobe.
- upg_adr_o  out  15  word address; bit14=0 selects instruction ROM, bit14=1 selects data memory.
- upg_dat_o  out  32  assembled word.
- upg_done_o  out  1  high when no download is active.
- busy_o  out  1  high in L_RECV.
- frame_err_o  out  1  sticky error flag.

Behaviour:
- Reset (async, rst=0):
  - Loader FSM = L_IDLE, RX FSM = R_IDLE, synchroniser flops = 1.
  - upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=1, busy_o=0, frame_err_o=0.
  - All counters = 0.
  - Reset mid-byte or mid-word discards all partial state.
- Synchroniser: rx_i passes through 2 flops; rxs is the output. All RX logic uses rxs only.
- RX FSM:
  - R_IDLE: rxs=0 -> R_START, bit counter cleared.
  - R_START: at count CLKS_PER_BIT/2 (integer divide), sample rxs. If 1: glitch, return to R_IDLE with no error. If 0: go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles. If 1: byte_valid pulses for 1 cycle. If 0: byte discarded and frame_err_o set. Either way, return to R_IDLE.
  - The RX FSM runs in every loader state. Bytes arriving outside L_RECV are dropped silently.
- Loader FSM:
  - L_IDLE:
    - start_i=1 -> L_RECV.
    - On that transition: upg_done_o=0, busy_o=1, upg_adr_o=0, byte index=0, frame_err_o=0, timeout counter=0, seen_byte=0.
  - L_RECV, on byte_valid:
    - byte goes into lane [8*idx+7:8*idx] of the assembly register; idx increments; seen_byte=1; timeout counter clears.
    - On the 4th byte (idx=3): the next cycle has upg_dat_o = full word and upg_wen_o=1 for exactly 1 cycle, with upg_adr_o holding the current address.
    - The cycle after the strobe: upg_adr_o increments and idx=0.
    - upg_dat_o holds its value until the next write.
  - L_RECV, capacity: if the write just issued was to MAX_WORDS-1, go to L_DONE in the cycle after the strobe. Address never wraps.
  - L_RECV, timeout:
    - The timeout counter increments every cycle while seen_byte=1.
    - It reaches TIMEOUT_BITS*CLKS_PER_BIT only if no byte arrives in that window; then go to L_DONE.
    - If idx != 0 at timeout: partial word discarded, no write, frame_err_o set.
  - L_RECV: start_i is ignored. With no bytes received, the FSM waits indefinitely.
  - L_DONE: 1 cycle; upg_done_o=1, busy_o=0; -> L_IDLE.
  - Simultaneous byte_valid and timeout terminal count: the byte wins and the counter clears.
- Latency: upg_wen_o rises 1 cycle after the byte_valid cycle of the 4th byte.
- Throughput: one write per 40 bit-times at most, so no backpressure is needed.
- upg_done_o is registered and changes only on state entry.

Test Plan:
- Reset, start_i pulse, send 0x78 0x56 0x34 0x12 at CLKS_PER_BIT=16 -> one upg_wen_o pulse with upg_adr_o=0, upg_dat_o=0x12345678; then upg_adr_o=1; after timeout, upg_done_o=1 and frame_err_o=0.
- Send 8 bytes 00..07 -> writes adr0=0x03020100, adr1=0x07060504; exactly 2 strobes; upg_done_o returns to 1 after TIMEOUT_BITS*16 idle cycles.
- Send 6 bytes -> 1 write only; at timeout, frame_err_o=1 and upg_done_o=1; the next start_i clears frame_err_o.
- Byte with stop bit=0 mid-stream -> byte dropped, frame_err_o=1, following bytes still pack in order; a 3-cycle low glitch on rx_i produces no byte and no error.
- MAX_WORDS=2, send 12 bytes -> exactly 2 strobes (adr 0, 1); L_DONE reached 1 cycle after the 2nd strobe; remaining bytes are ignored.
- Assert rst low mid-byte during L_RECV -> all outputs at reset values immediately (upg_done_o=1, upg_wen_o=0); no strobe after release.
